// File: rtl/npu_gemm.sv
// npu_gemm: N x N output-stationary systolic integer matrix multiply with a host-loaded
// flip-flop scratchpad and a valid/ready write-back stream of the result matrix.
module npu_gemm #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N         = 3,
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    localparam int unsigned NN    = N * N;
    localparam int unsigned MW    = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(NN + 3 * N);
    localparam int unsigned IW    = $clog2(NN);

    localparam logic [CNT_W-1:0]  FeedLast = CNT_W'(3 * N - 2);
    localparam logic [CNT_W-1:0]  WbLast   = CNT_W'(NN - 1);
    localparam logic [ADDR_W-1:0] NnA      = ADDR_W'(NN);
    localparam logic [ADDR_W-1:0] DepthA   = ADDR_W'(MEM_DEPTH);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StWb, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              latch;
    logic              acc_mode_q;
    logic [MW-1:0]     a_word_q, b_word_q, c_word_q;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [N-1:0][DATA_W-1:0]  a_edge_q, b_edge_q, a_feed, b_feed;
    logic [NN-1:0][DATA_W-1:0] acc_q, a_q, b_q, a_in, b_in, acc_init;

    logic [ADDR_W-1:0] a_wd, b_wd, c_wd;
    logic              range_ok;
    logic              ld_in_range;
    logic              wb_fire;
    logic [MW-1:0]     wb_word;
    logic              unused_lsbs;

    assign unused_lsbs = ^{ld_addr[1:0], a_base[1:0], b_base[1:0], c_base[1:0]};

    // Word bases are zero-extended by two bits so the range sum cannot overflow.
    assign a_wd     = {2'b00, a_base[ADDR_W-1:2]};
    assign b_wd     = {2'b00, b_base[ADDR_W-1:2]};
    assign c_wd     = {2'b00, c_base[ADDR_W-1:2]};
    assign range_ok = (a_wd + NnA <= DepthA) && (b_wd + NnA <= DepthA) &&
                      (c_wd + NnA <= DepthA);

    assign ld_in_range = {2'b00, ld_addr[ADDR_W-1:2]} < DepthA;

    assign busy     = state_q != StIdle;
    assign done     = state_q == StDone;
    assign err      = err_q;
    assign wb_valid = state_q == StWb;
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_word  = c_word_q + MW'(cnt_q);
    assign wb_data  = wb_valid ? acc_q[IW'(cnt_q)] : '0;
    assign wb_addr  = wb_valid ? ADDR_W'({wb_word, 2'b00}) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (range_ok) begin
                        state_d = StClear;
                        latch   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StClear: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (cnt_q == FeedLast) begin
                    state_d = StWb;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb: begin
                if (wb_fire) begin
                    if (cnt_q == WbLast) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            acc_mode_q <= 1'b0;
            a_word_q   <= '0;
            b_word_q   <= '0;
            c_word_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (latch) begin
                acc_mode_q <= acc_mode;
                a_word_q   <= a_base[MW+1:2];
                b_word_q   <= b_base[MW+1:2];
                c_word_q   <= c_base[MW+1:2];
            end
        end
    end

    // Skewed injection: edge i carries A[i][t-i] / B[t-i][i] while 0 <= t-i < N.
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (state_q == StFeed) begin
            for (int i = 0; i < N; i++) begin
                if (int'(cnt_q) >= i && int'(cnt_q) < i + N) begin
                    a_feed[i] = mem_q[a_word_q + MW'(i * N + int'(cnt_q) - i)];
                    b_feed[i] = mem_q[b_word_q + MW'((int'(cnt_q) - i) * N + i)];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i*N+j] = a_edge_q[i];
            end else begin : g_a_pass
                assign a_in[i*N+j] = a_q[i*N+j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i*N+j] = b_edge_q[j];
            end else begin : g_b_pass
                assign b_in[i*N+j] = b_q[(i-1)*N+j];
            end
            assign acc_init[i*N+j] = acc_mode_q ? mem_q[c_word_q + MW'(i * N + j)] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_edge_q <= '0;
            b_edge_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else if (state_q == StClear) begin
            a_edge_q <= '0;
            b_edge_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= acc_init;
        end else if (state_q == StFeed) begin
            a_edge_q <= a_feed;
            b_edge_q <= b_feed;
            a_q      <= a_in;
            b_q      <= b_in;
            for (int p = 0; p < NN; p++) begin
                acc_q[p] <= acc_q[p] + a_in[p] * b_in[p];
            end
        end
    end

    // Scratchpad is deliberately not reset so a partial write-back survives reset.
    always_ff @(posedge clk) begin
        if (wb_fire) begin
            mem_q[wb_word] <= wb_data;
        end else if (ld_we && !busy && ld_in_range) begin
            mem_q[ld_addr[MW+1:2]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_npu_gemm.sv
// tb_npu_gemm: table-driven job vectors for the N=3 engine plus hand-written sequences for
// range rejection, ignored restarts, reset during write-back and an N=4 instance.
module tb_npu_gemm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ld_we, start, acc_mode, busy, done, err, wb_valid, wb_ready;
    logic [31:0] ld_addr, ld_data, a_base, b_base, c_base, wb_addr, wb_data;

    logic        ld_we4, start4, acc4, busy4, done4, err4, valid4, ready4;
    logic [31:0] ld_addr4, ld_data4, a_base4, b_base4, c_base4, addr4, data4;

    npu_gemm #(.DATA_W(32), .N(3), .MEM_DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .acc_mode(acc_mode), .a_base(a_base), .b_base(b_base),
        .c_base(c_base), .busy(busy), .done(done), .err(err), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    npu_gemm #(.DATA_W(32), .N(4), .MEM_DEPTH(64), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(rst), .ld_we(ld_we4), .ld_addr(ld_addr4), .ld_data(ld_data4),
        .start(start4), .acc_mode(acc4), .a_base(a_base4), .b_base(b_base4),
        .c_base(c_base4), .busy(busy4), .done(done4), .err(err4), .wb_valid(valid4),
        .wb_ready(ready4), .wb_addr(addr4), .wb_data(data4)
    );

    typedef struct packed {
        logic [8:0][31:0] a;
        logic [8:0][31:0] b;
        logic [8:0][31:0] c0;
        logic [8:0][31:0] exp;
        logic             acc;
        logic             stall;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   gen_exp [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        ld_we = 1'b1; ld_addr = 32'(addr); ld_data = data;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic load_word4(input int addr, input logic [31:0] data);
        ld_we4 = 1'b1; ld_addr4 = 32'(addr); ld_data4 = data;
        @(posedge clk); #1;
        ld_we4 = 1'b0;
    endtask

    // A at word 0, B at word 9, C at word 18; optional bad restart at cycle restart_at.
    task automatic run_job(input vec_t vc, input int restart_at);
        int          beat, first_valid, done_cyc;
        logic        stalled;
        logic [31:0] hold_d, hold_a;
        beat = 0; first_valid = -1; done_cyc = -1; stalled = 1'b0; hold_d = '0; hold_a = '0;
        for (int k = 0; k < 9; k++) begin
            load_word(4 * k, vc.a[k]);
            load_word(36 + 4 * k, vc.b[k]);
            load_word(72 + 4 * k, vc.c0[k]);
        end
        a_base = 0; b_base = 36; c_base = 72; acc_mode = vc.acc; start = 1'b1;
        ld_we = 1'b1; ld_addr = 252; ld_data = 32'h00c0ffee;
        @(posedge clk); #1;
        start = 1'b0; ld_we = 1'b0;
        for (int cyc = 1; cyc < 120 && done_cyc < 0; cyc++) begin
            wb_ready = vc.stall ? (cyc % 3 == 1) : 1'b1;
            if (cyc == 1) chk("busy_rise", 32'(busy), 1);
            if (cyc == restart_at) begin
                start = 1'b1; c_base = 32'hf0; ld_we = 1'b1; ld_addr = 0; ld_data = 32'hbad;
            end
            if (cyc == restart_at + 1) begin
                start = 1'b0; ld_we = 1'b0;
                chk("restart_no_err", 32'(err), 0);
            end
            if (stalled) begin
                chk("stall_valid", 32'(wb_valid), 1);
                chk("stall_data", wb_data, hold_d);
                chk("stall_addr", wb_addr, hold_a);
            end
            stalled = 1'b0;
            if (wb_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (wb_ready) begin
                    if (beat < 9) begin
                        chk("wb_data", wb_data, vc.exp[beat]);
                        chk("wb_addr", wb_addr, 32'(72 + 4 * beat));
                    end
                    beat++;
                end else begin
                    stalled = 1'b1; hold_d = wb_data; hold_a = wb_addr;
                end
            end
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        chk("done_seen", 32'(done_cyc >= 0), 1);
        chk("beat_count", beat, 9);
        chk("first_valid", first_valid, 10);
        if (!vc.stall) chk("done_cycle", done_cyc, 19);
        chk("busy_fall", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
        for (int k = 0; k < 9; k++) chk("mem_c", dut.mem_q[6'(18 + k)], vc.exp[k]);
        chk("ld_with_start", dut.mem_q[6'(63)], 32'h00c0ffee);
        if (restart_at > 0) chk("ld_busy_dropped", dut.mem_q[6'(0)], vc.a[0]);
    endtask

    initial begin
        int beats, first4, seen;
        ld_we = 0; ld_addr = 0; ld_data = 0; start = 0; acc_mode = 0;
        a_base = 0; b_base = 0; c_base = 0; wb_ready = 0;
        ld_we4 = 0; ld_addr4 = 0; ld_data4 = 0; start4 = 0; acc4 = 0;
        a_base4 = 0; b_base4 = 0; c_base4 = 0; ready4 = 0;

        for (int k = 0; k < 9; k++) begin
            vecs[0].a[k] = 32'(k + 1);
            vecs[0].b[k] = (k % 4 == 0) ? 32'd1 : 32'd0;
            vecs[0].c0[k] = 32'hdead0000 + 32'(k);
            vecs[0].exp[k] = 32'(k + 1);
            vecs[1].a[k] = 32'(k + 1);
            vecs[1].b[k] = 32'(9 - k);
            vecs[1].c0[k] = 32'hdead0000 + 32'(k);
            vecs[1].exp[k] = 32'(gen_exp[k]);
            vecs[2].a[k] = 32'(k + 1);
            vecs[2].b[k] = 32'(9 - k);
            vecs[2].c0[k] = 32'd1;
            vecs[2].exp[k] = 32'(gen_exp[k] + 1);
            vecs[3].a[k] = 32'h00010000;
            vecs[3].b[k] = (k % 4 == 0) ? 32'd1 : 32'd0;
            vecs[3].c0[k] = 32'hdead0000 + 32'(k);
            vecs[3].exp[k] = 32'h00010000;
            vecs[4].a[k] = 32'h00010000;
            vecs[4].b[k] = 32'h00010000;
            vecs[4].c0[k] = 32'hdead0000 + 32'(k);
            vecs[4].exp[k] = 32'h0;
        end
        vecs[0].acc = 0; vecs[0].stall = 0;
        vecs[1].acc = 0; vecs[1].stall = 0;
        vecs[2].acc = 1; vecs[2].stall = 0;
        vecs[3].acc = 0; vecs[3].stall = 1;
        vecs[4].acc = 0; vecs[4].stall = 1;

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_valid", 32'(wb_valid), 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int v = 0; v < 5; v++) run_job(vecs[v], -1);

        // Out-of-range C base is rejected with a single err pulse.
        a_base = 0; b_base = 36; c_base = 32'hf0; acc_mode = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("range_err", 32'(err), 1);
        chk("range_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("range_err_pulse", 32'(err), 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (wb_valid || busy) seen = 1;
            @(posedge clk); #1;
        end
        chk("range_idle", seen, 0);

        run_job(vecs[0], 4);

        // Reset during write-back after four beats.
        for (int k = 0; k < 9; k++) begin
            load_word(4 * k, vecs[1].a[k]);
            load_word(36 + 4 * k, vecs[1].b[k]);
            load_word(72 + 4 * k, 32'h55550000 + 32'(k));
        end
        a_base = 0; b_base = 36; c_base = 72; acc_mode = 0; start = 1'b1; wb_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0;
        for (int c = 1; c < 100 && beats < 4; c++) begin
            if (wb_valid) beats++;
            @(posedge clk); #1;
        end
        chk("pre_rst_beats", beats, 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_valid", 32'(wb_valid), 0);
        chk("mid_rst_addr", wb_addr, 0);
        chk("mid_rst_data", wb_data, 0);
        for (int k = 0; k < 9; k++) begin
            chk("partial_c", dut.mem_q[6'(18 + k)],
                (k < 4) ? 32'(gen_exp[k]) : 32'h55550000 + 32'(k));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_job(vecs[1], -1);

        // N=4 instance: A = I at word 0, B = 1..16 at word 16, C at word 32.
        for (int k = 0; k < 16; k++) begin
            load_word4(4 * k, (k % 5 == 0) ? 32'd1 : 32'd0);
            load_word4(64 + 4 * k, 32'(k + 1));
        end
        a_base4 = 0; b_base4 = 64; c_base4 = 128; acc4 = 0; ready4 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        beats = 0; first4 = -1; seen = 0;
        for (int c = 1; c < 100 && seen == 0; c++) begin
            if (valid4) begin
                if (first4 < 0) first4 = c;
                if (beats < 16) begin
                    chk("n4_data", data4, 32'(beats + 1));
                    chk("n4_addr", addr4, 32'(128 + 4 * beats));
                end
                beats++;
            end
            if (done4) seen = 1;
            @(posedge clk); #1;
        end
        chk("n4_done_seen", seen, 1);
        chk("n4_beats", beats, 16);
        chk("n4_first_valid", first4, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
